// File: rtl/segre_pkg.sv
// Shared types and default constants for the segre main-memory responder.
package segre_pkg;

  localparam int unsigned ADDR_SIZE         = 32;
  localparam int unsigned LANE_SIZE         = 128;
  localparam int unsigned MEM_LANES         = 1024;
  localparam int unsigned MM_LATENCY        = 5;
  localparam int unsigned MM_REQ_FIFO_DEPTH = 4;

  localparam int unsigned MM_IDX_W = $clog2(MEM_LANES);
  localparam int unsigned MM_LB    = $clog2(LANE_SIZE / 8);

  typedef enum logic [1:0] {
    MM_IDLE = 2'd0,
    MM_BUSY = 2'd1,
    MM_RESP = 2'd2
  } mm_fsm_state_e;

  typedef struct packed {
    logic                 we;
    logic [MM_IDX_W-1:0]  idx;
    logic [LANE_SIZE-1:0] data;
  } mm_req_t;

endpackage

// File: rtl/segre_mm_responder_if.sv
// Request/response bundle between the cache MMU (master) and the main-memory responder (slave).
interface segre_mm_responder_if;
  import segre_pkg::*;

  logic                 rd_req_i;
  logic                 wr_req_i;
  logic [ADDR_SIZE-1:0] addr_i;
  logic [LANE_SIZE-1:0] data_i;
  logic                 data_rdy_o;
  logic [LANE_SIZE-1:0] data_o;
  logic                 busy_o;
  logic                 err_o;

  modport master (
    output rd_req_i, wr_req_i, addr_i, data_i,
    input  data_rdy_o, data_o, busy_o, err_o
  );

  modport slave (
    input  rd_req_i, wr_req_i, addr_i, data_i,
    output data_rdy_o, data_o, busy_o, err_o
  );

endinterface

// File: rtl/segre_mm_req_fifo.sv
// Synchronous FIFO of pending memory requests; head is visible combinationally, push+pop on full is legal.
module segre_mm_req_fifo
  import segre_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    push_i,
  input  logic    pop_i,
  input  mm_req_t data_i,
  output mm_req_t head_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  mm_req_t          slot_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + (PTR_W+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PTR_W+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) slot_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = slot_q[rd_ptr_q];
  assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/segre_mm_responder.sv
// Main-memory model: queues rd/wr pulses, answers each in FIFO order with a one-cycle lane pulse
// after LATENCY cycles. SEGRE_MM_RANDOM_LATENCY_EN adds 0..3 LFSR-chosen extra cycles per request.
module segre_mm_responder
  import segre_pkg::*;
#(
  parameter int unsigned LATENCY        = MM_LATENCY,
  parameter int unsigned REQ_FIFO_DEPTH = MM_REQ_FIFO_DEPTH
) (
  input logic                 clk_i,
  input logic                 rst_i,
  segre_mm_responder_if.slave mm
);

  localparam int unsigned      CNT_W    = 16;
  // Head of an empty queue is popped one cycle after its request, so one cycle is already spent.
  localparam logic [CNT_W-1:0] DLY_IDLE = (LATENCY >= 2) ? CNT_W'(LATENCY - 1) : CNT_W'(1);
  localparam logic [CNT_W-1:0] LAT_M1   = CNT_W'(LATENCY - 1);

  mm_fsm_state_e        state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 fetch_q, fetch_d;
  mm_req_t              cur_q;
  logic                 rdy_q;
  logic [LANE_SIZE-1:0] data_q;
  logic                 err_q;
  logic [LANE_SIZE-1:0] mem_q [MEM_LANES];

  mm_req_t          new_req, fifo_head, svc;
  logic             fifo_full, fifo_empty;
  logic             push_req, push, pop, start, err_set;
  logic [CNT_W-1:0] extra, dly_idle;
  logic             unused_addr;

  assign unused_addr = ^{mm.addr_i[ADDR_SIZE-1:MM_LB+MM_IDX_W], mm.addr_i[MM_LB-1:0]};

  always_comb begin
    new_req      = '0;
    new_req.we   = mm.wr_req_i;
    new_req.idx  = mm.addr_i[MM_LB +: MM_IDX_W];
    new_req.data = mm.data_i;
  end

  assign push_req = mm.rd_req_i | mm.wr_req_i;
  assign push     = push_req & (~fifo_full | pop);
  assign err_set  = (mm.rd_req_i & mm.wr_req_i) | (push_req & fifo_full & ~pop);

  segre_mm_req_fifo #(
    .DEPTH (REQ_FIFO_DEPTH)
  ) u_req_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (new_req),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef SEGRE_MM_RANDOM_LATENCY_EN
  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (start) lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lfsr_q <= 8'hA5;
    else       lfsr_q <= lfsr_d;
  end

  assign extra = CNT_W'(lfsr_q[1:0]);
`else
  assign extra = '0;
`endif

  assign dly_idle = DLY_IDLE + extra;

  // A service that follows a response pops its request in the first BUSY cycle (fetch_q).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fetch_d = 1'b0;
    pop     = 1'b0;
    start   = 1'b0;
    unique case (state_q)
      MM_IDLE: begin
        if (!fifo_empty) begin
          pop   = 1'b1;
          start = 1'b1;
          if (dly_idle == CNT_W'(1)) begin
            state_d = MM_RESP;
          end else begin
            state_d = MM_BUSY;
            cnt_d   = dly_idle - CNT_W'(2);
          end
        end
      end
      MM_BUSY: begin
        pop = fetch_q;
        if (cnt_q == '0) state_d = MM_RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      MM_RESP: begin
        if (!fifo_empty || push) begin
          start   = 1'b1;
          fetch_d = 1'b1;
          state_d = MM_BUSY;
          cnt_d   = LAT_M1 + extra;
        end else begin
          state_d = MM_IDLE;
        end
      end
      default: state_d = MM_IDLE;
    endcase
  end

  assign svc = pop ? fifo_head : cur_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= MM_IDLE;
      cnt_q   <= '0;
      fetch_q <= 1'b0;
      cur_q   <= '0;
      rdy_q   <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fetch_q <= fetch_d;
      if (pop) cur_q <= fifo_head;
      rdy_q <= (state_d == MM_RESP);
      if (state_d == MM_RESP) data_q <= svc.we ? svc.data : mem_q[svc.idx];
      if (err_set) err_q <= 1'b1;
    end
  end

  // Storage survives reset.
  always_ff @(posedge clk_i) begin
    if (state_d == MM_RESP && svc.we) mem_q[svc.idx] <= svc.data;
  end

  assign mm.data_rdy_o = rdy_q;
  assign mm.data_o     = data_q;
  assign mm.busy_o     = (state_q != MM_IDLE) | ~fifo_empty;
  assign mm.err_o      = err_q;

endmodule

// File: tb/tb_segre_mm_responder.sv
// Scoreboard bench for segre_mm_responder: expected lanes and response cycles queued at request time.
module tb_segre_mm_responder;
  import segre_pkg::*;

  localparam int L = MM_LATENCY;

  typedef struct {
    logic [LANE_SIZE-1:0] d;
    int                   c;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  segre_mm_responder_if mm();

  segre_mm_responder #(
    .LATENCY        (MM_LATENCY),
    .REQ_FIFO_DEPTH (MM_REQ_FIFO_DEPTH)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .mm    (mm)
  );

  exp_t                 sb[$];
  logic [LANE_SIZE-1:0] mem_m [MEM_LANES];
  logic [LANE_SIZE-1:0] last_d   = '0;
  int                   cyc      = 0;
  int                   last_rsp = -1000;
  int                   n_vec    = 0;
  int                   n_err    = 0;

  localparam logic [LANE_SIZE-1:0] D1 = {16'hDEAD, 104'h0, 8'h01};
  localparam logic [LANE_SIZE-1:0] DA = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [LANE_SIZE-1:0] DB = 128'hB0B0_1111_2222_3333_4444_5555_6666_7777;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [LANE_SIZE-1:0] got,
                       input logic [LANE_SIZE-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (mm.data_rdy_o === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_rsp", LANE_SIZE'(mm.data_rdy_o), '0);
      end else begin
        e = sb.pop_front();
        check("rsp_data", mm.data_o, e.d);
`ifdef SEGRE_MM_RANDOM_LATENCY_EN
        check("rsp_cycle_min", LANE_SIZE'(cyc >= e.c), LANE_SIZE'(1));
`else
        check("rsp_cycle", LANE_SIZE'(cyc), LANE_SIZE'(e.c));
`endif
      end
    end
  end

  task automatic req(input logic rd, input logic wr, input logic [ADDR_SIZE-1:0] a,
                     input logic [LANE_SIZE-1:0] d, input bit keep);
    exp_t e;
    int   idx;
    @(posedge clk); #1;
    mm.rd_req_i = rd;
    mm.wr_req_i = wr;
    mm.addr_i   = a;
    mm.data_i   = d;
    idx = int'(a[MM_LB +: MM_IDX_W]);
    if (keep) begin
      if (wr) mem_m[idx] = d;
      e.d = mem_m[idx];
      e.c = (cyc + L > last_rsp + 1 + L) ? cyc + L : last_rsp + 1 + L;
      last_rsp = e.c;
      last_d   = e.d;
      sb.push_back(e);
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    mm.rd_req_i = 1'b0;
    mm.wr_req_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    idle();
    while ((sb.size() != 0 || mm.busy_o !== 1'b0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("drain_timeout", LANE_SIZE'(n < 300), LANE_SIZE'(1));
    check("data_hold", mm.data_o, last_d);
  endtask

  task automatic do_reset(input int hold);
    @(posedge clk); #1;
    rst = 1'b1;
    mm.rd_req_i = 1'b0;
    mm.wr_req_i = 1'b0;
    repeat (hold) @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    last_rsp = -1000;
    last_d   = '0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin : stim
    mm.rd_req_i = 1'b0;
    mm.wr_req_i = 1'b0;
    mm.addr_i   = '0;
    mm.data_i   = '0;
    @(negedge clk);
    check("rst_data_rdy", LANE_SIZE'(mm.data_rdy_o), '0);
    check("rst_data",     mm.data_o, '0);
    check("rst_busy",     LANE_SIZE'(mm.busy_o), '0);
    check("rst_err",      LANE_SIZE'(mm.err_o), '0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Write at cycle 10, ack 5 cycles later; busy visible once queued.
    while (cyc < 9) @(posedge clk);
    req(1'b0, 1'b1, 32'h40, D1, 1'b1);
    idle();
    @(negedge clk);
    check("busy_pending", LANE_SIZE'(mm.busy_o), LANE_SIZE'(1));
    drain();

    // Read back, including an unaligned address in the same lane.
    req(1'b1, 1'b0, 32'h40, '0, 1'b1);
    req(1'b1, 1'b0, 32'h4C, '0, 1'b1);
    drain();

    // Back-to-back write/read to one lane, then an aliased address that wraps to it.
    req(1'b0, 1'b1, 32'h80, DA, 1'b1);
    req(1'b1, 1'b0, 32'h80, '0, 1'b1);
    req(1'b1, 1'b0, 32'hFFFF_C08F, '0, 1'b1);
    drain();
    check("err_clear", LANE_SIZE'(mm.err_o), '0);

    // Six consecutive reads: the sixth hits a full queue and is dropped.
    for (int i = 0; i < 5; i++) req(1'b1, 1'b0, (i % 2) ? 32'h80 : 32'h40, '0, 1'b1);
    req(1'b1, 1'b0, 32'h40, '0, 1'b0);
    @(negedge clk);
    check("ovf_err_before", LANE_SIZE'(mm.err_o), '0);
    idle();
    @(negedge clk);
    check("ovf_err_after", LANE_SIZE'(mm.err_o), LANE_SIZE'(1));
    drain();

    do_reset(1);
    @(negedge clk);
    check("err_reset", LANE_SIZE'(mm.err_o), '0);

    // Simultaneous rd+wr: only the write is serviced.
    req(1'b1, 1'b1, 32'h100, DB, 1'b1);
    idle();
    @(negedge clk);
    check("collide_err", LANE_SIZE'(mm.err_o), LANE_SIZE'(1));
    drain();
    req(1'b1, 1'b0, 32'h100, '0, 1'b1);
    drain();

    // Reset three cycles into a read: no response, memory kept.
    req(1'b1, 1'b0, 32'h100, '0, 1'b1);
    idle();
    idle();
    do_reset(1);
    @(negedge clk);
    check("midrst_busy",  LANE_SIZE'(mm.busy_o), '0);
    check("midrst_rdy",   LANE_SIZE'(mm.data_rdy_o), '0);
    check("midrst_err",   LANE_SIZE'(mm.err_o), '0);
    repeat (10) @(negedge clk);
    req(1'b1, 1'b0, 32'h100, '0, 1'b1);
    drain();
    check("sb_empty", LANE_SIZE'(sb.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
